// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares one RAM port between two cache-level requesters.
//             Round-robin grant, held until the RAM reports ACCESS, the
//             requester drops its request, or a timeout expires.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, nRST                 clock (rising edge), async active-low reset
//    reqN_ren/wen/addr/store   requester N access request (N = 0, 1)
//    reqN_wait                 requester N must hold its request
//    reqN_load                 read data returned to requester N
//    reqN_err                  one-cycle pulse: transaction timed out
//    ramaddr/ramstore          RAM address / write data
//    ramREN/ramWEN             RAM read / write enable
//    ramload/ramstate          RAM read data / status (FREE,BUSY,ACCESS,ERROR)
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0_ren,
  input  logic              req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_store,
  output logic              req0_wait,
  output logic [DATA_W-1:0] req0_load,
  output logic              req0_err,
  input  logic              req1_ren,
  input  logic              req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_store,
  output logic              req1_wait,
  output logic [DATA_W-1:0] req1_load,
  output logic              req1_err,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic              ramREN,
  output logic              ramWEN,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  logic [1:0]        fsm, fsm_next;
  logic              prio, prio_next;
  logic [TCNT_W-1:0] tcnt, tcnt_next;

  logic              req0, req1;
  logic              gnt1;
  logic              access;
  logic              sel_req, sel_ren, sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_store;
  logic              timeout_hit;

  assign req0   = req0_ren | req0_wen;
  assign req1   = req1_ren | req1_wen;
  assign access = (ramstate == RAM_ACCESS);

  // Mux of the currently selected requester; only meaningful in GNT0/GNT1.
  assign gnt1      = (fsm == GNT1);
  assign sel_req   = gnt1 ? req1       : req0;
  assign sel_ren   = gnt1 ? req1_ren   : req0_ren;
  assign sel_wen   = gnt1 ? req1_wen   : req0_wen;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_store = gnt1 ? req1_store : req0_store;

  // A dropped request is an abort, not a timeout, even at the limit.
  assign timeout_hit = sel_req && !access && (tcnt == TCNT_MAX);

  always_comb begin
    ramaddr   = '0;
    ramstore  = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    req0_wait = req0;
    req1_wait = req1;
    req0_load = '0;
    req1_load = '0;
    req0_err  = 1'b0;
    req1_err  = 1'b0;
    fsm_next  = fsm;
    prio_next = prio;
    tcnt_next = tcnt;

    case (fsm)
      IDLE: begin
        tcnt_next = '0;
        if (req0 && req1) begin
          fsm_next = prio ? GNT1 : GNT0;
        end else if (req0) begin
          fsm_next = GNT0;
        end else if (req1) begin
          fsm_next = GNT1;
        end
      end

      GNT0, GNT1: begin
        ramaddr  = sel_addr;
        ramstore = sel_store;
        ramWEN   = sel_wen;
        // Write takes precedence when both enables are raised.
        ramREN   = sel_ren & ~sel_wen;

        if (gnt1) begin
          req1_load = ramload;
          req1_wait = ~access;
          req1_err  = timeout_hit;
        end else begin
          req0_load = ramload;
          req0_wait = ~access;
          req0_err  = timeout_hit;
        end

        if (access) begin
          fsm_next  = IDLE;
          prio_next = ~gnt1;
          tcnt_next = '0;
        end else if (!sel_req) begin
          fsm_next  = IDLE;
          tcnt_next = '0;
        end else if (timeout_hit) begin
          fsm_next  = IDLE;
          prio_next = ~gnt1;
          tcnt_next = '0;
        end else begin
          // BUSY, FREE and ERROR all count as waiting; ERROR is a retry.
          tcnt_next = tcnt + TCNT_W'(1);
        end
      end

      default: begin
        fsm_next  = IDLE;
        tcnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fsm  <= IDLE;
      prio <= 1'b0;
      tcnt <= '0;
    end else begin
      fsm  <= fsm_next;
      prio <= prio_next;
      tcnt <= tcnt_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port (the cpu_ram interface signals) between two cache-level requesters, e.g. core 0 and core 1 caches in the dual-core build.
- Grants one requester at a time with round-robin fairness and holds the grant until the RAM reports ACCESS.
- Returns load data and wait/error status to the granted requester.
- Sits between the cache/memory-control blocks and the RAM port at the top level.

Parameters:
- ADDR_W, 32, request and RAM address width.
- DATA_W, 32, store and load data width.
- TIMEOUT, 255, maximum cycles a grant may wait for ACCESS before it is aborted with an error; must be ≥ 1.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req0_ren  in  1  requester 0 read request.
- req0_wen  in  1  requester 0 write request.
- req0_addr  in  ADDR_W  requester 0 address.
- req0_store  in  DATA_W  requester 0 write data.
- req0_wait  out  1  requester 0 must hold its request.
- req0_load  out  DATA_W  read data for requester 0.
- req0_err  out  1  one-cycle pulse: requester 0 transaction aborted by timeout.
- req1_ren, req1_wen, req1_addr, req1_store, req1_wait, req1_load, req1_err: same as requester 0, for requester 1.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Request definition: reqN = reqN_ren | reqN_wen. If both ren and wen are high, the access is a write: ramWEN=1, ramREN=0.
- Registered state: fsm ∈ {IDLE, GNT0, GNT1}, prio (1 bit, the requester favoured on a tie), tcnt (⌈log2(TIMEOUT+1)⌉ bits).
- Reset values: fsm=IDLE, prio=0, tcnt=0. All RAM outputs 0. reqN_err=0. reqN_wait = reqN (combinational).
- IDLE:
  - RAM outputs are 0.
  - If exactly one request is active, go to GNTn for that requester.
  - If both are active, go to GNT[prio].
  - tcnt is cleared.
  - Arbitration latency is 1 cycle: RAM signals are first driven the cycle after the request is seen.
- GNTn, RAM drive: ramaddr, ramstore, ramREN, ramWEN are driven combinationally from requester n.
- GNTn, outputs to requester n: reqn_load = ramload; reqn_wait = ~(ramstate==ACCESS).
- GNTn, ungranted requester m: reqm_wait = reqm; reqm_load = 0.
- GNTn, ramstate==ACCESS: the transaction completes this cycle. Next state IDLE, prio ← ~n, tcnt ← 0.
- GNTn, requester n drops both ren and wen: abort. Next state IDLE, prio unchanged, no error pulse, RAM outputs follow the dropped request (0).
- GNTn, ramstate BUSY, FREE or ERROR: stay in GNTn, tcnt increments. ERROR is treated as a retry and is not surfaced to the requester.
- Timeout: if tcnt==TIMEOUT and ramstate≠ACCESS, reqn_err pulses for 1 cycle, next state IDLE, prio ← ~n, tcnt ← 0. reqn_wait stays high in that cycle.
- ACCESS wins over timeout when both occur in the same cycle.
- Back-to-back requests: a requester still requesting after completion is re-arbitrated in IDLE. With both requesting, grants alternate 0,1,0,1 with one IDLE cycle between grants.
- Requests that change address mid-grant are passed through; the requester is responsible for holding them stable.
- Asynchronous reset at any point returns to IDLE and drops all RAM enables immediately. Any in-flight transaction is discarded.
- No combinational path from ramstate to fsm other than through the registered next-state.

Test Plan:
- Reset during GNT1 with ramREN=1 → ramREN=0 asynchronously; fsm=IDLE, prio=0 after release.
- Single read: req0_ren=1, addr=0x40; RAM returns BUSY×3 then ACCESS with ramload=0xDEADBEEF → ramREN high from cycle 1; req0_wait=0 and req0_load=0xDEADBEEF in the ACCESS cycle; IDLE next; prio=1.
- Simultaneous requests: req0_wen addr 0x10 data 0x1111 and req1_ren addr 0x20, RAM ACCESS after 1 cycle each → grant order 0,1,0,1 across 4 transactions; req1_wait stays high during GNT0.
- Both ren and wen on req1 → ramWEN=1, ramREN=0, ramstore=req1_store.
- Timeout with TIMEOUT=4: RAM held BUSY → req0_err pulses exactly once, 5 cycles after grant; fsm returns to IDLE; a pending req1 is granted next.
- Abort and retry: req0 drops mid-grant → IDLE, prio unchanged, no err. Separately, ERROR then ACCESS → completes normally, no err pulse.
